// File: rtl/interrupt_controller_if.sv
// Core/timer-facing signal bundle of the interrupt controller.
// The slave modport is the controller's view; master is the core/timer side.
interface interrupt_controller_if #(
  parameter int NUM_SRC  = 4,
  parameter int PC_WIDTH = 32
);
  localparam int CW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]  irq_src;
  logic [NUM_SRC-1:0]  irq_mask;
  logic [PC_WIDTH-1:0] pc;
  logic                instr_boundary;
  logic                irq_ack;
  logic                iret;
  logic                irq_req;
  logic [PC_WIDTH-1:0] irq_vector;
  logic [CW-1:0]       irq_cause;
  logic [PC_WIDTH-1:0] epc;
  logic                in_handler;
  logic                timer_stop;
  logic                timer_restart;

  modport slave (
    input  irq_src, irq_mask, pc, instr_boundary, irq_ack, iret,
    output irq_req, irq_vector, irq_cause, epc, in_handler, timer_stop, timer_restart
  );

  modport master (
    output irq_src, irq_mask, pc, instr_boundary, irq_ack, iret,
    input  irq_req, irq_vector, irq_cause, epc, in_handler, timer_stop, timer_restart
  );
endinterface

// File: rtl/interrupt_controller.sv
// Sticky-pending, fixed-priority interrupt controller with req/ack redirect,
// EPC capture, and timer stop/restart control around the handler.
module interrupt_controller #(
  parameter int                  NUM_SRC       = 4,
  parameter int                  PC_WIDTH      = 32,
  parameter logic [PC_WIDTH-1:0] VECTOR_BASE   = 32'h0000_0100,
  parameter int unsigned         VECTOR_STRIDE = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  interrupt_controller_if.slave  bus
);
  localparam int CW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HANDLER, S_RETURN} state_e;

  state_e              state_q, state_d;
  logic [NUM_SRC-1:0]  pending_q, pending_d;
  logic [NUM_SRC-1:0]  active, clr;
  logic [CW-1:0]       sel_idx;
  logic [CW-1:0]       cause_q, cause_d;
  logic [PC_WIDTH-1:0] vector_q, vector_d;
  logic [PC_WIDTH-1:0] epc_q, epc_d;
  logic                irq_req_q, irq_req_d;
  logic                in_handler_q, in_handler_d;
  logic                timer_stop_q, timer_stop_d;
  logic                timer_restart_q, timer_restart_d;

  // Index 0 wins: scan from the top so the lowest set index is written last.
  always_comb begin
    active  = pending_q & bus.irq_mask;
    sel_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) sel_idx = CW'(i);
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    cause_d  = cause_q;
    vector_d = vector_q;
    epc_d    = epc_q;
    clr      = '0;

    case (state_q)
      S_IDLE: begin
        if ((|active) && bus.instr_boundary) begin
          state_d  = S_REQ;
          cause_d  = sel_idx;
          epc_d    = bus.pc;
          vector_d = VECTOR_BASE + PC_WIDTH'(VECTOR_STRIDE) * PC_WIDTH'(sel_idx);
        end
      end
      S_REQ: begin
        if (bus.irq_ack) begin
          state_d      = S_HANDLER;
          clr[cause_q] = 1'b1;
        end
      end
      S_HANDLER: begin
        if (bus.iret) state_d = S_RETURN;
      end
      S_RETURN: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // A new event on the acknowledged source re-arms it in the same edge.
    pending_d = (pending_q & ~clr) | bus.irq_src;

    irq_req_d       = (state_d == S_REQ);
    in_handler_d    = (state_d == S_HANDLER);
    timer_stop_d    = (state_d == S_REQ) || (state_d == S_HANDLER);
    timer_restart_d = (state_d == S_RETURN);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      pending_q       <= '0;
      cause_q         <= '0;
      vector_q        <= '0;
      epc_q           <= '0;
      irq_req_q       <= 1'b0;
      in_handler_q    <= 1'b0;
      timer_stop_q    <= 1'b0;
      timer_restart_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      cause_q         <= cause_d;
      vector_q        <= vector_d;
      epc_q           <= epc_d;
      irq_req_q       <= irq_req_d;
      in_handler_q    <= in_handler_d;
      timer_stop_q    <= timer_stop_d;
      timer_restart_q <= timer_restart_d;
    end
  end

  assign bus.irq_req       = irq_req_q;
  assign bus.irq_vector    = vector_q;
  assign bus.irq_cause     = cause_q;
  assign bus.epc           = epc_q;
  assign bus.in_handler    = in_handler_q;
  assign bus.timer_stop    = timer_stop_q;
  assign bus.timer_restart = timer_restart_q;
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: inputs change and outputs are
// sampled on the falling edge, away from the rising active edge.
module tb_interrupt_controller;
  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  interrupt_controller_if #(.NUM_SRC(4), .PC_WIDTH(32)) bus ();

  interrupt_controller #(
    .NUM_SRC(4), .PC_WIDTH(32), .VECTOR_BASE(32'h0000_0100), .VECTOR_STRIDE(4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".irq_req"},       32'(bus.irq_req),       32'h0);
    check({tag, ".in_handler"},    32'(bus.in_handler),    32'h0);
    check({tag, ".timer_stop"},    32'(bus.timer_stop),    32'h0);
    check({tag, ".timer_restart"}, 32'(bus.timer_restart), 32'h0);
  endtask

  // Ack the open request, return, and let RETURN fall back to IDLE.
  task automatic service();
    bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
    bus.iret    = 1'b1; tick(); bus.iret    = 1'b0;
    tick();
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    reset          = 1'b0;
    bus.irq_src    = '0;
    bus.irq_mask   = 4'hF;
    bus.pc         = 32'h40;
    bus.instr_boundary = 1'b1;
    bus.irq_ack    = 1'b0;
    bus.iret       = 1'b0;

    // Reset state
    tick(); tick();
    check_idle_outputs("rst");
    check("rst.irq_vector", bus.irq_vector, 32'h0);
    check("rst.irq_cause",  32'(bus.irq_cause), 32'h0);
    check("rst.epc",        bus.epc, 32'h0);
    reset = 1'b1;
    tick();

    // Timer pulse on source 3
    bus.irq_src = 4'b1000; tick(); bus.irq_src = '0;
    check("t1.req_after_1", 32'(bus.irq_req), 32'h0);
    tick();
    check("t1.irq_req",    32'(bus.irq_req), 32'h1);
    check("t1.irq_cause",  32'(bus.irq_cause), 32'h3);
    check("t1.irq_vector", bus.irq_vector, 32'h10C);
    check("t1.epc",        bus.epc, 32'h40);
    check("t1.timer_stop", 32'(bus.timer_stop), 32'h1);
    bus.pc = 32'h44; tick();
    check("t1.epc_frozen", bus.epc, 32'h40);
    bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
    check("t1.ack_req",        32'(bus.irq_req), 32'h0);
    check("t1.ack_in_handler", 32'(bus.in_handler), 32'h1);
    check("t1.ack_stop",       32'(bus.timer_stop), 32'h1);
    bus.iret = 1'b1; tick(); bus.iret = 1'b0;
    check("t1.iret_in_handler", 32'(bus.in_handler), 32'h0);
    check("t1.iret_stop",       32'(bus.timer_stop), 32'h0);
    check("t1.iret_restart",    32'(bus.timer_restart), 32'h1);
    tick();
    check_idle_outputs("t1.after_return");
    tick();
    check("t1.no_rerequest", 32'(bus.irq_req), 32'h0);

    // iret in IDLE is ignored
    bus.iret = 1'b1; tick(); bus.iret = 1'b0;
    check_idle_outputs("iret_idle");

    // Priority and freeze
    bus.pc = 32'h80;
    bus.irq_src = 4'b1010; tick(); bus.irq_src = '0;
    tick();
    check("t2.req",    32'(bus.irq_req), 32'h1);
    check("t2.cause",  32'(bus.irq_cause), 32'h1);
    check("t2.vector", bus.irq_vector, 32'h104);
    bus.irq_src = 4'b0001; tick(); bus.irq_src = '0;
    check("t2.frozen_cause",  32'(bus.irq_cause), 32'h1);
    check("t2.frozen_vector", bus.irq_vector, 32'h104);
    service();
    check("t2.idle_gap", 32'(bus.irq_req), 32'h0);
    tick();
    check("t2.src0_req",    32'(bus.irq_req), 32'h1);
    check("t2.src0_cause",  32'(bus.irq_cause), 32'h0);
    check("t2.src0_vector", bus.irq_vector, 32'h100);
    service();
    tick();
    check("t2.src3_cause",  32'(bus.irq_cause), 32'h3);
    check("t2.src3_vector", bus.irq_vector, 32'h10C);
    service();
    tick();
    check("t2.drained", 32'(bus.irq_req), 32'h0);

    // Boundary gating
    bus.instr_boundary = 1'b0;
    bus.irq_src = 4'b0100; tick(); bus.irq_src = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3.no_boundary", 32'(bus.irq_req), 32'h0);
    end
    bus.instr_boundary = 1'b1; tick();
    check("t3.boundary_req",    32'(bus.irq_req), 32'h1);
    check("t3.boundary_cause",  32'(bus.irq_cause), 32'h2);
    check("t3.boundary_vector", bus.irq_vector, 32'h108);
    service();

    // Masked source stays pending; masking mid-REQ does not cancel
    bus.irq_mask = 4'b1101;
    bus.irq_src = 4'b0010; tick(); bus.irq_src = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4.masked", 32'(bus.irq_req), 32'h0);
    end
    bus.irq_mask = 4'hF; tick();
    check("t4.unmasked_req",   32'(bus.irq_req), 32'h1);
    check("t4.unmasked_cause", 32'(bus.irq_cause), 32'h1);
    bus.irq_mask = 4'h0; tick();
    check("t4.mask_mid_req", 32'(bus.irq_req), 32'h1);
    bus.irq_mask = 4'hF;
    service();
    tick();
    check("t4.drained", 32'(bus.irq_req), 32'h0);

    // Set/clear collision on source 3
    bus.irq_src = 4'b1000; tick(); bus.irq_src = '0;
    tick();
    check("t5.req_cause", 32'(bus.irq_cause), 32'h3);
    bus.irq_ack = 1'b1; bus.irq_src = 4'b1000; tick();
    bus.irq_ack = 1'b0; bus.irq_src = '0;
    check("t5.in_handler", 32'(bus.in_handler), 32'h1);
    bus.iret = 1'b1; tick(); bus.iret = 1'b0;
    check("t5.restart", 32'(bus.timer_restart), 32'h1);
    tick();
    check("t5.restart_one_cycle", 32'(bus.timer_restart), 32'h0);
    check("t5.idle_gap", 32'(bus.irq_req), 32'h0);
    tick();
    check("t5.rerequest", 32'(bus.irq_req), 32'h1);
    check("t5.recause",   32'(bus.irq_cause), 32'h3);
    service();

    // Asynchronous reset in REQ
    bus.pc = 32'hC0;
    bus.irq_src = 4'b0001; tick(); bus.irq_src = '0;
    tick();
    check("t6.req_before_rst", 32'(bus.irq_req), 32'h1);
    #2 reset = 1'b0;
    #1;
    check_idle_outputs("t6.async");
    check("t6.async_vector", bus.irq_vector, 32'h0);
    check("t6.async_epc",    bus.epc, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    tick(); tick();
    check_idle_outputs("t6.after_release");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
